// File: rtl/mul_seq_if.sv
// Request/response and shared-ALU signals of the sequential multiplier.
// The slave modport is the multiplier's view; master is the requester/ALU side.
interface mul_seq_if #(
  parameter int unsigned N = 64
);
  logic         start;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         busy;
  logic         done;
  logic [N-1:0] product;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_result;

  modport master (
    output start, op_a, op_b, alu_result,
    input  busy, done, product, alu_a, alu_b, alu_ctrl
  );

  modport slave (
    input  start, op_a, op_b, alu_result,
    output busy, done, product, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/mul_seq.sv
// Shift-and-add unsigned multiplier (low N bits of the product) that borrows
// an external combinational adder for every accumulate step.
module mul_seq #(
  parameter int unsigned N = 64
) (
  input logic      clk,
  input logic      reset_n,
  mul_seq_if.slave bus
);

  localparam int unsigned CW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0]  ALU_ADD = 4'b0010;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [N-1:0]   product_q, product_d;
  logic [CW-1:0]  count_q, count_d;
  logic           run_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  // Finish early once no multiplier bits remain above the current one.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    count_d   = count_q;
    run_last  = ((mplier_q >> 1) == '0) || (count_q == CW'(N - 1));
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = bus.alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (run_last) begin
          product_d = bus.alu_result;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q == RUN);
    bus.done     = (state_q == DONE);
    bus.alu_ctrl = ALU_ADD;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    if (state_q == RUN) begin
      bus.alu_a = acc_q;
      bus.alu_b = mplier_q[0] ? mcand_q : '0;
    end
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: the shared ALU is an ideal adder and every
// cycle is compared against an arithmetic model of partial products.
module tb_mul_seq;

  localparam int unsigned N = 64;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  mul_seq_if #(.N(N)) bus ();

  assign bus.alu_result = bus.alu_a + bus.alu_b;

  mul_seq #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    vectors++;
    if (bus.busy === 1'b1 && bus.done === 1'b1) begin
      miscompares++;
      $display("FAIL busy_done_excl: busy=%b done=%b required not both high", bus.busy, bus.done);
    end
  end

  function automatic logic [N-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  // Number of RUN cycles: position of the highest set multiplier bit, minimum 1.
  function automatic int unsigned exp_cycles(input logic [N-1:0] b);
    for (int i = N - 1; i >= 0; i--)
      if (b[i]) return i + 1;
    return 1;
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
    int unsigned  k;
    logic [N-1:0] exp_p, exp_aa, exp_ab, mask;
    k     = exp_cycles(b);
    exp_p = a * b;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    for (int i = 0; i < int'(k); i++) begin
      if (hold) begin bus.op_a = rnd(); bus.op_b = rnd(); end
      mask   = (i == 0) ? '0 : ({N{1'b1}} >> (N - i));
      exp_aa = a * (b & mask);
      exp_ab = b[i] ? (a << i) : '0;
      vectors++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL run_flags: cycle %0d busy=%b done=%b required busy=1 done=0", i, bus.busy, bus.done);
      end
      vectors++;
      if (bus.alu_a !== exp_aa) begin
        miscompares++;
        $display("FAIL run_alu_a: cycle %0d got %h required %h", i, bus.alu_a, exp_aa);
      end
      vectors++;
      if (bus.alu_b !== exp_ab) begin
        miscompares++;
        $display("FAIL run_alu_b: cycle %0d got %h required %h", i, bus.alu_b, exp_ab);
      end
      vectors++;
      if (bus.alu_ctrl !== 4'b0010) begin
        miscompares++;
        $display("FAIL run_alu_ctrl: got %b required 0010", bus.alu_ctrl);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_flags: a=%h b=%h done=%b busy=%b required done=1 busy=0", a, b, bus.done, bus.busy);
    end
    vectors++;
    if (bus.product !== exp_p) begin
      miscompares++;
      $display("FAIL product: a=%h b=%h got %h required %h", a, b, bus.product, exp_p);
    end
    vectors++;
    if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_ctrl !== 4'b0010) begin
      miscompares++;
      $display("FAIL done_alu_drive: alu_a=%h alu_b=%h ctrl=%b required 0/0/0010", bus.alu_a, bus.alu_b, bus.alu_ctrl);
    end
    if (hold) begin bus.op_a = rnd(); bus.op_b = rnd(); end
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_done: done=%b busy=%b required 0/0", bus.done, bus.busy);
    end
    vectors++;
    if (bus.product !== exp_p) begin
      miscompares++;
      $display("FAIL product_hold: got %h required %h", bus.product, exp_p);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.op_a  = rnd();
    bus.op_b  = rnd();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: busy=%b done=%b required 0/0", bus.busy, bus.done);
    end
    vectors++;
    if (bus.product !== '0) begin
      miscompares++;
      $display("FAIL reset_product: got %h required 0", bus.product);
    end
    vectors++;
    if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_ctrl !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_alu: alu_a=%h alu_b=%h ctrl=%b required 0/0/0010", bus.alu_a, bus.alu_b, bus.alu_ctrl);
    end
    reset_n   = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.product !== '0) begin
      miscompares++;
      $display("FAIL idle_hold: busy=%b product=%h required 0/0", bus.busy, bus.product);
    end
  endtask

  task automatic test_directed();
    run_op(64'd3, 64'd5, 1'b0);
    run_op('1, '1, 1'b0);
    run_op(64'd7, 64'd0, 1'b0);
    run_op(64'd2, 64'h8000_0000_0000_0000, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      run_op(rnd(), rnd() >> $urandom_range(0, N - 1), 1'b0);
  endtask

  task automatic test_hold_start();
    for (int n = 0; n < 4; n++)
      run_op(rnd() >> $urandom_range(0, N - 1), rnd() >> $urandom_range(40, N - 1), 1'b1);
    bus.start = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_op(64'd11, 64'd13, 1'b0);
    run_op(64'd1000, 64'd1000, 1'b0);
    run_op(rnd(), rnd(), 1'b0);
  endtask

  task automatic test_reset_mid_run();
    run_op(64'd5, 64'd5, 1'b0);
    bus.start = 1'b1;
    bus.op_a  = 64'd9;
    bus.op_b  = 64'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_busy: got %b required 1", bus.busy);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: busy=%b done=%b product=%h required 0/0/0", bus.busy, bus.done, bus.product);
    end
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== '0) begin
        miscompares++;
        $display("FAIL aborted_op: done=%b busy=%b product=%h required 0/0/0", bus.done, bus.busy, bus.product);
      end
    end
    run_op(64'd9, 64'd9, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.op_a    = '0;
    bus.op_b    = '0;
    test_reset();
    test_directed();
    test_random();
    test_hold_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
